// File: rtl/voting_machine_n.sv
// voting_machine_n: N-candidate voting machine with press-and-hold vote
// qualification, saturating per-candidate tallies, a running total,
// leader/tie tracking and a result-mode tally display.
module voting_machine_n #(
    parameter int NUM_CAND    = 4,
    parameter int CNT_W       = 8,
    parameter int HOLD_CYCLES = 10
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic                                 mode,
    input  logic [NUM_CAND-1:0]                  button,
    output logic [CNT_W-1:0]                     led,
    output logic                                 vote_valid,
    output logic [$clog2(NUM_CAND)-1:0]          leader,
    output logic                                 tie,
    output logic [CNT_W+$clog2(NUM_CAND)-1:0]    total,
    output logic                                 overflow
);

    localparam int IDX_W = $clog2(NUM_CAND);
    localparam int TOT_W = CNT_W + IDX_W;
    localparam int HC_W  = $clog2(HOLD_CYCLES + 1);

    localparam logic [HC_W-1:0]     HOLD_LIM = HC_W'(HOLD_CYCLES);
    localparam logic [NUM_CAND-1:0] BTN_ONE  = NUM_CAND'(1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_HOLD     = 2'd1,
        S_WAIT_REL = 2'd2
    } state_t;

    state_t            state_q;
    logic [IDX_W-1:0]  cand_q;
    logic [HC_W-1:0]   hold_cnt_q;

    logic [CNT_W-1:0]  tally_q [NUM_CAND];
    logic [TOT_W-1:0]  total_q;
    logic              vote_valid_q;
    logic              overflow_q;

    logic [IDX_W-1:0]  sel_q;
    logic [IDX_W-1:0]  sel_d;
    logic [CNT_W-1:0]  led_q;

    logic [IDX_W-1:0]  leader_q;
    logic [IDX_W-1:0]  leader_d;
    logic              tie_q;
    logic              tie_d;

    logic              lone_press;
    logic              any_press;
    logic              same_press;
    logic [IDX_W-1:0]  btn_idx;
    logic [HC_W-1:0]   hold_cnt_inc;
    logic              accept;
    logic [IDX_W-1:0]  accept_idx;

    // Lowest-index set bit; for a one-hot pattern this is simply its index.
    function automatic logic [IDX_W-1:0] lowest_idx(input logic [NUM_CAND-1:0] b);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = NUM_CAND - 1; i >= 0; i--) begin
            if (b[i]) r = IDX_W'(i);
        end
        return r;
    endfunction

    // A tally at all-ones cannot take another vote.
    function automatic logic is_saturated(input logic [CNT_W-1:0] t);
        return (t == {CNT_W{1'b1}});
    endfunction

    assign any_press    = (button != '0);
    assign lone_press   = any_press && ((button & (button - BTN_ONE)) == '0);
    assign btn_idx      = lowest_idx(button);
    assign same_press   = (button == (BTN_ONE << cand_q));
    assign hold_cnt_inc = hold_cnt_q + HC_W'(1);

    // Vote request: the qualifier has seen enough consecutive lone-press samples.
    always_comb begin
        accept     = 1'b0;
        accept_idx = cand_q;
        if (!mode) begin
            case (state_q)
                S_IDLE: begin
                    accept_idx = btn_idx;
                    if (lone_press && (HOLD_CYCLES == 1)) accept = 1'b1;
                end
                S_HOLD: begin
                    if (same_press && (hold_cnt_inc == HOLD_LIM)) accept = 1'b1;
                end
                default: accept = 1'b0;
            endcase
        end
    end

    // Press-and-hold qualifier: one vote per press, frozen while in result mode.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cand_q     <= '0;
            hold_cnt_q <= '0;
        end else if (!mode) begin
            case (state_q)
                S_IDLE: begin
                    if (lone_press) begin
                        cand_q     <= btn_idx;
                        hold_cnt_q <= HC_W'(1);
                        if (HOLD_CYCLES == 1) state_q <= S_WAIT_REL;
                        else                  state_q <= S_HOLD;
                    end else if (any_press) begin
                        state_q <= S_WAIT_REL;
                    end
                end
                S_HOLD: begin
                    if (same_press) begin
                        hold_cnt_q <= hold_cnt_inc;
                        if (hold_cnt_inc == HOLD_LIM) state_q <= S_WAIT_REL;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_WAIT_REL: begin
                    if (!any_press) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end else if (state_q == S_HOLD) begin
            state_q <= S_IDLE;
        end
    end

    // Tallies and total: saturating increment, sticky overflow on a rejected vote.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CAND; i++) tally_q[i] <= '0;
            total_q      <= '0;
            vote_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            vote_valid_q <= 1'b0;
            if (accept) begin
                if (is_saturated(tally_q[accept_idx])) begin
                    overflow_q <= 1'b1;
                end else begin
                    tally_q[accept_idx] <= tally_q[accept_idx] + CNT_W'(1);
                    total_q             <= total_q + TOT_W'(1);
                    vote_valid_q        <= 1'b1;
                end
            end
        end
    end

    // Leader is the first strict maximum; tie means another candidate shares a nonzero maximum.
    always_comb begin
        logic [CNT_W-1:0] best;
        best     = tally_q[0];
        leader_d = '0;
        tie_d    = 1'b0;
        for (int i = 1; i < NUM_CAND; i++) begin
            if (tally_q[i] > best) begin
                best     = tally_q[i];
                leader_d = IDX_W'(i);
            end
        end
        for (int i = 0; i < NUM_CAND; i++) begin
            if ((IDX_W'(i) != leader_d) && (tally_q[i] == best) && (best != '0)) tie_d = 1'b1;
        end
    end

    // Register leader/tie every cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            leader_q <= '0;
            tie_q    <= 1'b0;
        end else begin
            leader_q <= leader_d;
            tie_q    <= tie_d;
        end
    end

    // In result mode the lowest pressed button picks the displayed candidate.
    assign sel_d = (mode && any_press) ? btn_idx : sel_q;

    // Display select and LED: selected tally in result mode, 0 while voting.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sel_q <= '0;
            led_q <= '0;
        end else begin
            sel_q <= sel_d;
            if (mode) led_q <= tally_q[sel_d];
            else      led_q <= '0;
        end
    end

    assign led        = led_q;
    assign vote_valid = vote_valid_q;
    assign leader     = leader_q;
    assign tie        = tie_q;
    assign total      = total_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_voting_machine_n.sv
// Directed self-checking bench for voting_machine_n. Instance a uses
// HOLD_CYCLES=4 with 8-bit tallies; instance b uses HOLD_CYCLES=1 with
// 2-bit tallies to reach saturation quickly.
module tb_voting_machine_n;

    logic       clock = 1'b0;
    logic       reset = 1'b1;

    logic       mode_a = 1'b0;
    logic [3:0] button_a = '0;
    logic [7:0] led_a;
    logic       vv_a;
    logic [1:0] leader_a;
    logic       tie_a;
    logic [9:0] total_a;
    logic       ovf_a;

    logic       mode_b = 1'b0;
    logic [3:0] button_b = '0;
    logic [1:0] led_b;
    logic       vv_b;
    logic [1:0] leader_b;
    logic       tie_b;
    logic [3:0] total_b;
    logic       ovf_b;

    int n_checks = 0;
    int n_fail   = 0;
    int pulses;

    voting_machine_n #(.NUM_CAND(4), .CNT_W(8), .HOLD_CYCLES(4)) dut_a (
        .clock(clock), .reset(reset), .mode(mode_a), .button(button_a),
        .led(led_a), .vote_valid(vv_a), .leader(leader_a), .tie(tie_a),
        .total(total_a), .overflow(ovf_a)
    );

    voting_machine_n #(.NUM_CAND(4), .CNT_W(2), .HOLD_CYCLES(1)) dut_b (
        .clock(clock), .reset(reset), .mode(mode_b), .button(button_b),
        .led(led_b), .vote_valid(vv_b), .leader(leader_b), .tie(tie_b),
        .total(total_b), .overflow(ovf_b)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL timeout: observed no end of test, expected $finish");
        $fatal(1, "bench timed out");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Hold a pattern on dut_a for n edges, release for one edge, count vote pulses.
    task automatic press_a(input logic [3:0] pat, input int n, output int cnt);
        cnt = 0;
        button_a = pat;
        repeat (n) begin
            tick();
            if (vv_a === 1'b1) cnt++;
        end
        button_a = '0;
        tick();
        if (vv_a === 1'b1) cnt++;
    endtask

    initial begin
        // Reset state
        #2 reset = 1'b0;
        #1;
        check("rst_total", total_a, 0);
        check("rst_led", led_a, 0);
        check("rst_vv", vv_a, 0);
        check("rst_leader", leader_a, 0);
        check("rst_tie", tie_a, 0);
        check("rst_ovf", ovf_a, 0);
        @(negedge clock);
        reset = 1'b1;

        // Single vote: 4-cycle hold of button 0
        button_a = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold0_early_vv", vv_a, 0);
        end
        tick();
        check("hold0_vv_e3", vv_a, 1);
        check("hold0_total", total_a, 1);
        button_a = '0;
        tick();
        check("hold0_vv_one_cycle", vv_a, 0);
        check("hold0_leader", leader_a, 0);
        check("hold0_tie", tie_a, 0);

        // Short press (release on the would-be accept sample) gives no vote
        press_a(4'b0010, 3, pulses);
        check("short_press_pulses", pulses, 0);
        check("short_press_total", total_a, 1);

        // Long hold gives exactly one vote
        press_a(4'b0010, 20, pulses);
        check("long_press_pulses", pulses, 1);
        check("long_press_total", total_a, 2);
        tick();
        check("tie_leader", leader_a, 0);
        check("tie_flag", tie_a, 1);

        // Two buttons at once: no vote
        press_a(4'b0110, 10, pulses);
        check("multi_press_pulses", pulses, 0);

        // Change of button mid-hold: no vote
        pulses = 0;
        button_a = 4'b0100;
        repeat (2) begin tick(); if (vv_a === 1'b1) pulses++; end
        button_a = 4'b1000;
        repeat (2) begin tick(); if (vv_a === 1'b1) pulses++; end
        button_a = '0;
        tick();
        if (vv_a === 1'b1) pulses++;
        check("change_press_pulses", pulses, 0);
        check("change_press_total", total_a, 2);

        // Build tallies {2,1,5,1}
        press_a(4'b0001, 4, pulses);
        check("build0_pulses", pulses, 1);
        for (int k = 0; k < 5; k++) begin
            press_a(4'b0100, 4, pulses);
            check("build2_pulses", pulses, 1);
        end
        press_a(4'b1000, 4, pulses);
        check("build3_pulses", pulses, 1);
        check("build_total", total_a, 9);
        check("build_leader", leader_a, 2);
        check("build_tie", tie_a, 0);

        // Result mode display
        mode_a = 1'b1;
        button_a = 4'b0100;
        tick();
        check("disp_led_c2", led_a, 5);
        button_a = '0;
        tick();
        check("disp_led_held", led_a, 5);
        button_a = 4'b0011;
        tick();
        check("disp_led_lowest", led_a, 2);
        button_a = 4'b0010;
        tick();
        check("disp_led_c1", led_a, 1);
        pulses = 0;
        button_a = 4'b0001;
        repeat (6) begin tick(); if (vv_a === 1'b1) pulses++; end
        check("disp_no_vote_pulses", pulses, 0);
        check("disp_no_vote_total", total_a, 9);
        button_a = '0;
        mode_a = 1'b0;
        tick();
        check("disp_led_vote_mode", led_a, 0);

        // Button held through a mode toggle while waiting for release
        pulses = 0;
        button_a = 4'b0001;
        repeat (4) begin tick(); if (vv_a === 1'b1) pulses++; end
        mode_a = 1'b1;
        repeat (2) begin tick(); if (vv_a === 1'b1) pulses++; end
        mode_a = 1'b0;
        repeat (6) begin tick(); if (vv_a === 1'b1) pulses++; end
        button_a = '0;
        tick();
        check("toggle_pulses", pulses, 1);
        check("toggle_total", total_a, 10);

        // Saturation on dut_b (2-bit tallies, immediate acceptance)
        for (int p = 1; p <= 5; p++) begin
            button_b = 4'b1000;
            tick();
            check("sat_vv", vv_b, (p <= 3) ? 1 : 0);
            check("sat_total", total_b, (p <= 3) ? p : 3);
            check("sat_ovf", ovf_b, (p >= 4) ? 1 : 0);
            button_b = '0;
            tick();
            check("sat_vv_release", vv_b, 0);
        end
        check("sat_leader", leader_b, 3);
        check("sat_tie", tie_b, 0);

        // Asynchronous reset mid-hold
        button_a = 4'b0100;
        tick();
        tick();
        #2 reset = 1'b0;
        #1;
        check("async_total", total_a, 0);
        check("async_leader", leader_a, 0);
        check("async_tie", tie_a, 0);
        check("async_led", led_a, 0);
        check("async_vv", vv_a, 0);
        check("async_ovf_b", ovf_b, 0);
        check("async_total_b", total_b, 0);
        #1 reset = 1'b1;
        pulses = 0;
        repeat (3) begin tick(); if (vv_a === 1'b1) pulses++; end
        button_a = '0;
        tick();
        if (vv_a === 1'b1) pulses++;
        check("post_reset_pulses", pulses, 0);
        check("post_reset_total", total_a, 0);

        // A fresh full press after reset still counts
        press_a(4'b0100, 4, pulses);
        check("post_reset_vote", pulses, 1);
        check("post_reset_vote_total", total_a, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
